up_down_count_param: RTL and testbench
======================================

# up_down_count_param

Parametrised up/down counter pair: the next-generation replacement for the fixed 4-bit up/down counter pair. One counter increments and the other decrements by a programmable step on each enabled cycle. The block adds:
- a swap command that exchanges the two counts;
- a synchronous load;
- selectable wrap or saturate behaviour;
- registered terminal-event flags and an equality flag.

It sits wherever a free-running paired counter is needed, typically driven by control logic that issues one-cycle Enable, Swap and Load pulses.

## Interface
Parameters:
- WIDTH, 4, counter width in bits (≥2)
- SATURATE, 0, 0 = modulo 2^WIDTH wrap, 1 = clamp at 0 / 2^WIDTH-1
- UP_INIT, 0, reset value of UpCountS
- DOWN_INIT, 2^WIDTH-1, reset value of DownCountS

Ports:
- Clock  in  1  single clock, all state updates on rising edge
- ResetN  in  1  asynchronous, active-low reset
- Enable  in  1  count/swap qualifier
- Swap  in  1  exchange counts when Enable=1
- Load  in  1  synchronous load, highest priority, independent of Enable
- LoadValue  in  WIDTH  value for Load
- Step  in  WIDTH  increment/decrement magnitude
- UpCountS  out  WIDTH  up counter value
- DownCountS  out  WIDTH  down counter value
- UpTerm  out  1  registered pulse: up counter overflowed (wrapped or clamped) on last update
- DownTerm  out  1  registered pulse: down counter underflowed (wrapped or clamped) on last update
- Match  out  1  combinational, UpCountS == DownCountS

## Operation
- Reset (ResetN=0, asynchronous assert, synchronous-safe deassert):
  - UpCountS=UP_INIT, DownCountS=DOWN_INIT
  - UpTerm=0, DownTerm=0
  - held while low
- Per-edge priority, highest first:
  - Load=1: UpCountS<=LoadValue, DownCountS<=~LoadValue (bitwise, i.e. 2^WIDTH-1-LoadValue); flags<=0.
  - Enable=1, Swap=1: UpCountS<=DownCountS, DownCountS<=UpCountS (old values); flags<=0.
  - Enable=1, Swap=0: count, see below.
  - Enable=0 (and no Load): both counters hold; flags<=0. Swap is ignored when Enable=0.
- Count arithmetic, computed at WIDTH+1 bits:
  - Up: sum = UpCountS + Step. Carry=1 is overflow.
  - Down: Step > DownCountS is underflow.
- On overflow:
  - SATURATE=0: UpCountS <= sum mod 2^WIDTH.
  - SATURATE=1: UpCountS <= 2^WIDTH-1.
  - UpTerm<=1 in both modes.
- On underflow:
  - SATURATE=0: DownCountS <= (DownCountS-Step) mod 2^WIDTH.
  - SATURATE=1: DownCountS <= 0.
  - DownTerm<=1 in both modes.
- Otherwise the plain sum/difference is stored and the flag <=0.
- Saturated counter already at its limit with Step>0: value stays and the flag re-asserts on every enabled count cycle.
- Step=0: counters hold, flags 0, even with Enable=1.
- Up and down counters evaluate overflow independently; both flags may assert on the same edge.

## Timing
- All outputs except Match are registers: one-cycle latency from a sampled command to the new value.
- UpTerm/DownTerm become valid on the same edge as the counter update that caused them. They last exactly one cycle unless the next cycle also over/underflows.
- Match follows the registered counters combinationally; there is no added latency.
- Commands are level-sampled each edge; no handshake. A multi-cycle Enable counts every cycle. A multi-cycle Swap with Enable swaps every cycle, so counts alternate.
- ResetN assertion mid-count clears immediately (asynchronous) and discards any command sampled in that cycle.

## Test plan
- Reset, WIDTH=4, defaults: ResetN low then high -> UpCountS=0, DownCountS=15, UpTerm=DownTerm=0, Match=0.
- Wrap count, Step=1, Enable high 16 cycles from reset:
  - after 15 cycles, Up=15 and Down=0.
  - cycle 16: Up=0, Down=15, UpTerm=DownTerm=1 for one cycle.
  - Match=1 never (4-bit complementary pair).
- Saturate, SATURATE=1, Step=6, Enable high from Up=0/Down=15:
  - Up 6,12,15 (UpTerm=1 on the third edge); Down 9,3,0 (DownTerm=1 on the third edge).
  - 4th cycle: values hold, both flags 1 again.
- Swap: Up=3, Down=10, Enable=1, Swap=1 one cycle -> Up=10, Down=3, flags 0. Swap=1 with Enable=0 -> no change.
- Priority: Load=1, LoadValue=5, with Enable=Swap=1 -> Up=5, Down=10. Then Step=0, Enable=1 -> hold, flags 0.
- Async reset mid-run: ResetN pulsed low between edges while counting -> outputs return to UP_INIT/DOWN_INIT before the next edge, flags 0.

Source files
------------

// File: rtl/up_down_count_param.sv
`default_nettype none
// ============================================================================
// Module   : up_down_count_param
// Brief    : Paired up/down counter with programmable step, swap, synchronous
//            load, wrap-or-saturate arithmetic, registered terminal flags and
//            a combinational equality flag.
// Revision : 1.0 - initial release
// ============================================================================
module up_down_count_param #(
  parameter int                WIDTH     = 4,
  parameter int                SATURATE  = 0,
  parameter logic [WIDTH-1:0]  UP_INIT   = '0,
  parameter logic [WIDTH-1:0]  DOWN_INIT = '1
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             Enable,
  input  logic             Swap,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadValue,
  input  logic [WIDTH-1:0] Step,
  output logic [WIDTH-1:0] UpCountS,
  output logic [WIDTH-1:0] DownCountS,
  output logic             UpTerm,
  output logic             DownTerm,
  output logic             Match
);

  localparam logic [WIDTH-1:0] c_MAX = '1;
  localparam logic [WIDTH-1:0] c_MIN = '0;

  // Registered state
  logic [WIDTH-1:0] r_up_count;
  logic [WIDTH-1:0] r_down_count;
  logic             r_up_term;
  logic             r_down_term;

  // Arithmetic at WIDTH+1 bits: the extra MSB is the carry (up) or borrow (down)
  logic [WIDTH:0]   w_up_sum;
  logic [WIDTH:0]   w_down_diff;
  logic             w_up_ovf;
  logic             w_down_unf;
  logic [WIDTH-1:0] w_up_counted;
  logic [WIDTH-1:0] w_down_counted;

  // Next-state values selected by command priority
  logic [WIDTH-1:0] w_up_next;
  logic [WIDTH-1:0] w_down_next;
  logic             w_up_term_next;
  logic             w_down_term_next;

  assign w_up_sum    = {1'b0, r_up_count}   + {1'b0, Step};
  assign w_down_diff = {1'b0, r_down_count} - {1'b0, Step};
  assign w_up_ovf    = w_up_sum[WIDTH];
  // A borrow out of the extended subtraction is exactly Step > DownCountS
  assign w_down_unf  = w_down_diff[WIDTH];

  // Out-of-range behaviour is fixed at elaboration: clamp or keep modulo bits
  generate
    if (SATURATE != 0) begin : g_saturate
      assign w_up_counted   = w_up_ovf   ? c_MAX : w_up_sum[WIDTH-1:0];
      assign w_down_counted = w_down_unf ? c_MIN : w_down_diff[WIDTH-1:0];
    end else begin : g_wrap
      assign w_up_counted   = w_up_sum[WIDTH-1:0];
      assign w_down_counted = w_down_diff[WIDTH-1:0];
    end
  endgenerate

  // Command priority: Load, then Swap (qualified by Enable), then count, else hold.
  // Flags are pulses, so every path other than an out-of-range count clears them.
  always_comb begin
    w_up_next        = r_up_count;
    w_down_next      = r_down_count;
    w_up_term_next   = 1'b0;
    w_down_term_next = 1'b0;
    if (Load) begin
      w_up_next   = LoadValue;
      w_down_next = ~LoadValue;
    end else if (Enable && Swap) begin
      w_up_next   = r_down_count;
      w_down_next = r_up_count;
    end else if (Enable) begin
      // Step=0 naturally yields hold with no carry/borrow, so no special case
      w_up_next        = w_up_counted;
      w_down_next      = w_down_counted;
      w_up_term_next   = w_up_ovf;
      w_down_term_next = w_down_unf;
    end
  end

  // State register with asynchronous active-low reset to the init values
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_up_count   <= UP_INIT;
      r_down_count <= DOWN_INIT;
      r_up_term    <= 1'b0;
      r_down_term  <= 1'b0;
    end else begin
      r_up_count   <= w_up_next;
      r_down_count <= w_down_next;
      r_up_term    <= w_up_term_next;
      r_down_term  <= w_down_term_next;
    end
  end

  assign UpCountS   = r_up_count;
  assign DownCountS = r_down_count;
  assign UpTerm     = r_up_term;
  assign DownTerm   = r_down_term;
  // Equality follows the registers directly, with no extra latency
  assign Match      = (r_up_count == r_down_count);

endmodule
`default_nettype wire

// File: tb/tb_up_down_count_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_up_down_count_param
// Brief    : Directed self-checking bench for up_down_count_param. Three
//            instances share one stimulus stream: wrap (defaults), saturate,
//            and wrap with non-default init values so Match can be exercised.
// Revision : 1.0 - initial release
// ============================================================================
module tb_up_down_count_param;

  localparam int W = 4;

  logic         Clock = 1'b0;
  logic         ResetN;
  logic         Enable;
  logic         Swap;
  logic         Load;
  logic [W-1:0] LoadValue;
  logic [W-1:0] Step;

  logic [W-1:0] up0, dn0, up1, dn1, up2, dn2;
  logic         ut0, dt0, m0, ut1, dt1, m1, ut2, dt2, m2;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  up_down_count_param #(.WIDTH(W), .SATURATE(0)) dut_wrap (
    .Clock(Clock), .ResetN(ResetN), .Enable(Enable), .Swap(Swap), .Load(Load),
    .LoadValue(LoadValue), .Step(Step), .UpCountS(up0), .DownCountS(dn0),
    .UpTerm(ut0), .DownTerm(dt0), .Match(m0));

  up_down_count_param #(.WIDTH(W), .SATURATE(1)) dut_sat (
    .Clock(Clock), .ResetN(ResetN), .Enable(Enable), .Swap(Swap), .Load(Load),
    .LoadValue(LoadValue), .Step(Step), .UpCountS(up1), .DownCountS(dn1),
    .UpTerm(ut1), .DownTerm(dt1), .Match(m1));

  up_down_count_param #(.WIDTH(W), .SATURATE(0), .UP_INIT(4'd3), .DOWN_INIT(4'd5)) dut_init (
    .Clock(Clock), .ResetN(ResetN), .Enable(Enable), .Swap(Swap), .Load(Load),
    .LoadValue(LoadValue), .Step(Step), .UpCountS(up2), .DownCountS(dn2),
    .UpTerm(ut2), .DownTerm(dt2), .Match(m2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Check all outputs of one instance against expected values
  task automatic chk_dut(input string tag, input int idx, input int eu, input int ed,
                         input int eut, input int edt, input int em);
    logic [W-1:0] u, d;
    logic         t_u, t_d, mm;
    case (idx)
      0:       begin u = up0; d = dn0; t_u = ut0; t_d = dt0; mm = m0; end
      1:       begin u = up1; d = dn1; t_u = ut1; t_d = dt1; mm = m1; end
      default: begin u = up2; d = dn2; t_u = ut2; t_d = dt2; mm = m2; end
    endcase
    chk({tag, ".up"},    32'(u),   32'(eu));
    chk({tag, ".down"},  32'(d),   32'(ed));
    chk({tag, ".upt"},   32'(t_u), 32'(eut));
    chk({tag, ".downt"}, 32'(t_d), 32'(edt));
    chk({tag, ".match"}, 32'(mm),  32'(em));
  endtask

  // Advance one clock edge and settle away from it
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    ResetN = 1'b0; Enable = 1'b0; Swap = 1'b0; Load = 1'b0;
    LoadValue = '0; Step = '0;

    // Reset held low
    tick(); tick();
    chk_dut("rst_wrap", 0, 0, 15, 0, 0, 0);
    chk_dut("rst_sat",  1, 0, 15, 0, 0, 0);
    chk_dut("rst_init", 2, 3, 5, 0, 0, 0);
    ResetN = 1'b1;
    tick();
    chk_dut("idle_wrap", 0, 0, 15, 0, 0, 0);

    // Wrap count, Step=1, 16 enabled cycles
    Step = 4'd1; Enable = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk_dut($sformatf("cnt%0d", i), 0, i, 15 - i, 0, 0, 0);
      if (i == 1)  chk_dut("init_match", 2, 4, 4, 0, 0, 1);
      if (i == 2)  chk_dut("init_nomatch", 2, 5, 3, 0, 0, 0);
      if (i == 15) chk_dut("sat_cnt15", 1, 15, 0, 0, 0, 0);
    end
    tick();
    chk_dut("wrap16", 0, 0, 15, 1, 1, 0);
    chk_dut("sat16",  1, 15, 0, 1, 1, 0);
    Enable = 1'b0;
    tick();
    chk_dut("hold_wrap", 0, 0, 15, 0, 0, 0);
    chk_dut("hold_sat",  1, 15, 0, 0, 0, 0);

    // Step=6 from reset: saturating vs wrapping
    ResetN = 1'b0;
    tick();
    ResetN = 1'b1; Step = 4'd6; Enable = 1'b1;
    tick();
    chk_dut("s6a_sat",  1, 6, 9, 0, 0, 0);
    chk_dut("s6a_wrap", 0, 6, 9, 0, 0, 0);
    tick();
    chk_dut("s6b_sat",  1, 12, 3, 0, 0, 0);
    chk_dut("s6b_wrap", 0, 12, 3, 0, 0, 0);
    tick();
    chk_dut("s6c_sat",  1, 15, 0, 1, 1, 0);
    chk_dut("s6c_wrap", 0, 2, 13, 1, 1, 0);
    tick();
    chk_dut("s6d_sat",  1, 15, 0, 1, 1, 0);
    chk_dut("s6d_wrap", 0, 8, 7, 0, 0, 0);

    // Load then swap
    Enable = 1'b0; Load = 1'b1; LoadValue = 4'd3;
    tick();
    chk_dut("load3", 0, 3, 12, 0, 0, 0);
    chk_dut("load3_sat", 1, 3, 12, 0, 0, 0);
    Load = 1'b0; Enable = 1'b1; Swap = 1'b1;
    tick();
    chk_dut("swap1", 0, 12, 3, 0, 0, 0);
    Enable = 1'b0;
    tick();
    chk_dut("swap_noen", 0, 12, 3, 0, 0, 0);
    Enable = 1'b1;
    tick();
    chk_dut("swap_alt1", 0, 3, 12, 0, 0, 0);
    tick();
    chk_dut("swap_alt2", 0, 12, 3, 0, 0, 0);

    // Load beats Enable+Swap; then Step=0 holds
    Load = 1'b1; LoadValue = 4'd5;
    tick();
    chk_dut("prio_load", 0, 5, 10, 0, 0, 0);
    chk_dut("prio_load_sat", 1, 5, 10, 0, 0, 0);
    Load = 1'b0; Swap = 1'b0; Step = 4'd0;
    tick();
    chk_dut("step0a", 0, 5, 10, 0, 0, 0);
    tick();
    chk_dut("step0b", 1, 5, 10, 0, 0, 0);

    // Exact boundary: 14+2 = 16, 1-2 = -1; then Load clears flags
    Enable = 1'b0; Load = 1'b1; LoadValue = 4'd14;
    tick();
    Load = 1'b0; Enable = 1'b1; Step = 4'd2;
    tick();
    chk_dut("edge_wrap", 0, 0, 15, 1, 1, 0);
    chk_dut("edge_sat",  1, 15, 0, 1, 1, 0);
    Load = 1'b1; LoadValue = 4'd5;
    tick();
    chk_dut("load_clr", 1, 5, 10, 0, 0, 0);

    // Asynchronous reset between edges while flags are active
    LoadValue = 4'd15;
    tick();
    Load = 1'b0; Step = 4'd1;
    tick();
    chk_dut("pre_ar_sat",  1, 15, 0, 1, 1, 0);
    chk_dut("pre_ar_wrap", 0, 0, 15, 1, 1, 0);
    @(negedge Clock);
    ResetN = 1'b0;
    #1;
    chk_dut("ar_sat",  1, 0, 15, 0, 0, 0);
    chk_dut("ar_wrap", 0, 0, 15, 0, 0, 0);
    chk_dut("ar_init", 2, 3, 5, 0, 0, 0);
    tick();
    chk_dut("ar_held", 1, 0, 15, 0, 0, 0);
    ResetN = 1'b1;
    tick();
    chk_dut("ar_resume", 0, 1, 14, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
